counter_wrap_monitor: RTL and testbench

//  Downstream consumer of an 8-bit loadable modulus up-counter (counts 0..MOD_MAX, then clears to 0).

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_wrap_detect.sv | 38 +++
 rtl/counter_wrap_monitor.sv | 118 +++++++++++
 tb/tb_counter_wrap_monitor.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and types for the upstream modulus counter and its wrap monitor.
package counter_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int MOD_MAX_DEF    = 46;
  localparam int WRAP_WIDTH_DEF = 8;
  localparam int WRAP_MAX_DEF   = 59;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_t;

endpackage

// File: rtl/counter_wrap_detect.sv
// Watches consecutive upstream counter values and flags a natural wrap (terminal value, then 0, no load).
module counter_wrap_detect
  import counter_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MOD_MAX = MOD_MAX_DEF
) (
  input  logic             clk,
  input  logic             reset_al_in,
  input  logic [WIDTH-1:0] count_i,
  input  logic             load_i,
  output logic             wrap_o,
  output logic             wrap_pulse_o
);

  localparam logic [WIDTH-1:0] ModMax = WIDTH'(MOD_MAX);

  logic [WIDTH-1:0] prevCount_q;
  logic             loadD_q;
  logic             wrapPulse_q;

  // prevCount_q resets to 0, so an upstream reset to 0 never looks like a wrap.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      prevCount_q <= '0;
      loadD_q     <= 1'b0;
      wrapPulse_q <= 1'b0;
    end else begin
      prevCount_q <= count_i;
      loadD_q     <= load_i;
      wrapPulse_q <= wrap_o;
    end
  end

  assign wrap_o       = (prevCount_q >= ModMax) && (count_i == '0) && !loadD_q;
  assign wrap_pulse_o = wrapPulse_q;

endmodule

// File: rtl/counter_wrap_monitor.sv
// Wrap monitor for the modulus up-counter: wrap pulse, modulo wrap count with sticky overflow,
// and a valid/ready snapshot port for the register/debug block.
module counter_wrap_monitor
  import counter_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MOD_MAX    = MOD_MAX_DEF,
  parameter int WRAP_WIDTH = WRAP_WIDTH_DEF,
  parameter int WRAP_MAX   = WRAP_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  reset_al_in,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  count_load_in,
  input  logic                  clear_in,
  input  logic                  snap_req_in,
  input  logic                  snap_ready_in,
  output logic                  wrap_pulse_out,
  output logic [WRAP_WIDTH-1:0] wrap_count_out,
  output logic                  overflow_out,
  output logic                  snap_valid_out,
  output logic [WIDTH-1:0]      snap_count_out,
  output logic [WRAP_WIDTH-1:0] snap_wraps_out,
  output logic                  snap_drop_out
);

  localparam logic [WRAP_WIDTH-1:0] WrapMax = WRAP_WIDTH'(WRAP_MAX);

  logic                  wrap;
  logic [WRAP_WIDTH-1:0] wrapCount_q, wrapCount_d;
  logic                  overflow_q, overflow_d;
  snap_state_t           state_q;
  logic                  snapValid_q;
  logic [WIDTH-1:0]      snapCount_q;
  logic [WRAP_WIDTH-1:0] snapWraps_q;
  logic                  snapDrop_q;

  counter_wrap_detect #(
    .WIDTH   (WIDTH),
    .MOD_MAX (MOD_MAX)
  ) u_detect (
    .clk          (clk),
    .reset_al_in  (reset_al_in),
    .count_i      (count_in),
    .load_i       (count_load_in),
    .wrap_o       (wrap),
    .wrap_pulse_o (wrap_pulse_out)
  );

  // Clear beats a coincident wrap, which is simply lost.
  always_comb begin
    wrapCount_d = wrapCount_q;
    overflow_d  = overflow_q;
    if (clear_in) begin
      wrapCount_d = '0;
      overflow_d  = 1'b0;
    end else if (wrap) begin
      if (wrapCount_q == WrapMax) begin
        wrapCount_d = '0;
        overflow_d  = 1'b1;
      end else begin
        wrapCount_d = wrapCount_q + WRAP_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      wrapCount_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wrapCount_q <= wrapCount_d;
      overflow_q  <= overflow_d;
    end
  end

  // The snapshot takes the wrap count as it stood before this edge's update.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      state_q     <= IDLE;
      snapValid_q <= 1'b0;
      snapCount_q <= '0;
      snapWraps_q <= '0;
      snapDrop_q  <= 1'b0;
    end else begin
      snapDrop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (snap_req_in) begin
            snapCount_q <= count_in;
            snapWraps_q <= wrapCount_q;
            snapValid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          snapDrop_q <= snap_req_in;
          if (snap_ready_in) begin
            snapValid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          snapValid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign wrap_count_out = wrapCount_q;
  assign overflow_out   = overflow_q;
  assign snap_valid_out = snapValid_q;
  assign snap_count_out = snapCount_q;
  assign snap_wraps_out = snapWraps_q;
  assign snap_drop_out  = snapDrop_q;

endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Scoreboard bench for counter_wrap_monitor: a cycle model pushes expected outputs as stimulus is driven.
module tb_counter_wrap_monitor;

  typedef struct packed {
    logic       pulse;
    logic [7:0] wcnt;
    logic       ovf;
    logic       valid;
    logic [7:0] scnt;
    logic [7:0] swr;
    logic       drop;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset_al_in;
  logic [7:0] count_in;
  logic       count_load_in, clear_in, snap_req_in, snap_ready_in;
  logic       wrap_pulse_out, overflow_out, snap_valid_out, snap_drop_out;
  logic [7:0] wrap_count_out, snap_count_out, snap_wraps_out;

  int   total = 0;
  int   bad = 0;
  obs_t sbq[$];
  obs_t mOut;
  logic [7:0] mPrev;
  logic mLoad, mHold;

  counter_wrap_monitor dut (
    .clk            (clk),
    .reset_al_in    (reset_al_in),
    .count_in       (count_in),
    .count_load_in  (count_load_in),
    .clear_in       (clear_in),
    .snap_req_in    (snap_req_in),
    .snap_ready_in  (snap_ready_in),
    .wrap_pulse_out (wrap_pulse_out),
    .wrap_count_out (wrap_count_out),
    .overflow_out   (overflow_out),
    .snap_valid_out (snap_valid_out),
    .snap_count_out (snap_count_out),
    .snap_wraps_out (snap_wraps_out),
    .snap_drop_out  (snap_drop_out)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.pulse = wrap_pulse_out;
    o.wcnt  = wrap_count_out;
    o.ovf   = overflow_out;
    o.valid = snap_valid_out;
    o.scnt  = snap_count_out;
    o.swr   = snap_wraps_out;
    o.drop  = snap_drop_out;
    return o;
  endfunction

  task automatic model_reset();
    mOut  = '0;
    mPrev = 8'd0;
    mLoad = 1'b0;
    mHold = 1'b0;
    sbq.delete();
  endtask

  // Drive one cycle, predict the post-edge outputs, then wait until just after the edge.
  task automatic step(input logic [7:0] c, input logic ld, input logic cl, input logic rq, input logic rd);
    obs_t e;
    logic w;
    count_in      = c;
    count_load_in = ld;
    clear_in      = cl;
    snap_req_in   = rq;
    snap_ready_in = rd;
    w = (mPrev >= 8'd46) && (c == 8'd0) && !mLoad;
    e = mOut;
    e.pulse = w;
    e.drop  = 1'b0;
    if (cl) begin
      e.wcnt = 8'd0;
      e.ovf  = 1'b0;
    end else if (w) begin
      if (mOut.wcnt == 8'd59) begin
        e.wcnt = 8'd0;
        e.ovf  = 1'b1;
      end else begin
        e.wcnt = mOut.wcnt + 8'd1;
      end
    end
    if (!mHold) begin
      if (rq) begin
        e.valid = 1'b1;
        e.scnt  = c;
        e.swr   = mOut.wcnt;
        mHold   = 1'b1;
      end
    end else begin
      e.drop = rq;
      if (rd) begin
        e.valid = 1'b0;
        mHold   = 1'b0;
      end
    end
    mPrev = c;
    mLoad = ld;
    mOut  = e;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    reset_al_in = 1'b0;
    count_in = 8'd17; count_load_in = 1'b0; clear_in = 1'b0;
    snap_req_in = 1'b1; snap_ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (observe() !== obs_t'('0)) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %h want 0", observe());
    end
    model_reset();
    reset_al_in = 1'b1;
    step(8'd17, 1'b0, 1'b0, 1'b1, 1'b1);
    e = sbq.pop_front(); total++;
    if (observe() !== e) begin
      bad++;
      $display("[TB] FAIL reset_first_req: got %h want %h", observe(), e);
    end
    total++;
    if (snap_valid_out !== 1'b1 || snap_count_out !== 8'd17) begin
      bad++;
      $display("[TB] FAIL reset_snap17: got valid=%b count=%0d want valid=1 count=17", snap_valid_out, snap_count_out);
    end
    step(8'd17, 1'b0, 1'b0, 1'b0, 1'b1);
    e = sbq.pop_front(); total++;
    if (observe() !== e) begin
      bad++;
      $display("[TB] FAIL reset_release_ack: got %h want %h", observe(), e);
    end
  endtask

  task automatic test_natural_wrap();
    obs_t e;
    logic [7:0] seq [5] = '{8'd44, 8'd45, 8'd46, 8'd0, 8'd1};
    logic       pul [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(seq[i], 1'b0, 1'b0, 1'b0, 1'b0);
      e = sbq.pop_front(); total++;
      if (observe() !== e) begin
        bad++;
        $display("[TB] FAIL natural_wrap[%0d]: got %h want %h", i, observe(), e);
      end
      total++;
      if (wrap_pulse_out !== pul[i]) begin
        bad++;
        $display("[TB] FAIL natural_wrap_pulse[%0d]: got %b want %b", i, wrap_pulse_out, pul[i]);
      end
    end
    total++;
    if (wrap_count_out !== 8'd1) begin
      bad++;
      $display("[TB] FAIL natural_wrap_count: got %0d want 1", wrap_count_out);
    end
  endtask

  task automatic test_load_zero();
    obs_t e;
    logic [7:0] seq [4] = '{8'd46, 8'd0, 8'd50, 8'd0};
    logic       ld  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic       pul [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step(seq[i], ld[i], 1'b0, 1'b0, 1'b0);
      e = sbq.pop_front(); total++;
      if (observe() !== e) begin
        bad++;
        $display("[TB] FAIL load_zero[%0d]: got %h want %h", i, observe(), e);
      end
      total++;
      if (wrap_pulse_out !== pul[i]) begin
        bad++;
        $display("[TB] FAIL load_zero_pulse[%0d]: got %b want %b", i, wrap_pulse_out, pul[i]);
      end
    end
    total++;
    if (wrap_count_out !== 8'd2) begin
      bad++;
      $display("[TB] FAIL load_zero_count: got %0d want 2", wrap_count_out);
    end
  endtask

  task automatic test_rollover();
    obs_t e;
    step(8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    e = sbq.pop_front(); total++;
    if (observe() !== e) begin
      bad++;
      $display("[TB] FAIL rollover_clear: got %h want %h", observe(), e);
    end
    for (int i = 0; i < 60; i++) begin
      step(8'd46 + 8'(i % 3), 1'b0, 1'b0, 1'b0, 1'b0);
      step(8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        e = sbq.pop_front(); total++;
        if (k == 1 && observe() !== e) begin
          bad++;
          $display("[TB] FAIL rollover_wrap[%0d]: got %h want %h", i, observe(), e);
        end
      end
      if (i == 58) begin
        total++;
        if (wrap_count_out !== 8'd59 || overflow_out !== 1'b0) begin
          bad++;
          $display("[TB] FAIL rollover_at_max: got cnt=%0d ovf=%b want cnt=59 ovf=0", wrap_count_out, overflow_out);
        end
      end
    end
    total++;
    if (wrap_count_out !== 8'd0 || overflow_out !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rollover_wrapped: got cnt=%0d ovf=%b want cnt=0 ovf=1", wrap_count_out, overflow_out);
    end
    step(8'd47, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'd48, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      e = sbq.pop_front();
    end
    total++;
    if (observe() !== e || wrap_count_out !== 8'd0 || overflow_out !== 1'b0 || wrap_pulse_out !== 1'b1) begin
      bad++;
      $display("[TB] FAIL clear_vs_wrap: got %h want %h", observe(), e);
    end
  endtask

  task automatic test_handshake();
    obs_t e;
    step(8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(8'd46, 1'b0, 1'b0, 1'b0, 1'b0);
      step(8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    while (sbq.size() > 0) e = sbq.pop_front();
    step(8'd20, 1'b0, 1'b0, 1'b1, 1'b0);
    e = sbq.pop_front(); total++;
    if (observe() !== e || snap_count_out !== 8'd20 || snap_wraps_out !== 8'd5 || snap_valid_out !== 1'b1) begin
      bad++;
      $display("[TB] FAIL hs_capture: got %h want %h (snap 20/5)", observe(), e);
    end
    for (int i = 0; i < 3; i++) begin
      step((i == 1) ? 8'd0 : 8'd46, 1'b0, 1'b0, 1'b0, 1'b0);
      e = sbq.pop_front(); total++;
      if (observe() !== e || snap_count_out !== 8'd20 || snap_wraps_out !== 8'd5) begin
        bad++;
        $display("[TB] FAIL hs_hold[%0d]: got %h want %h", i, observe(), e);
      end
    end
    step(8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    e = sbq.pop_front(); total++;
    if (observe() !== e || snap_drop_out !== 1'b1 || snap_count_out !== 8'd20) begin
      bad++;
      $display("[TB] FAIL hs_drop: got %h want %h", observe(), e);
    end
    step(8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    e = sbq.pop_front(); total++;
    if (observe() !== e || snap_valid_out !== 1'b0 || snap_drop_out !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hs_release: got %h want %h", observe(), e);
    end
    step(8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    e = sbq.pop_front(); total++;
    if (observe() !== e) begin
      bad++;
      $display("[TB] FAIL hs_ready_idle: got %h want %h", observe(), e);
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    logic [7:0] seq [8] = '{8'd46, 8'd0, 8'd9, 8'd10, 8'd46, 8'd0, 8'd47, 8'd0};
    for (int i = 0; i < 8; i++) begin
      step(seq[i], 1'b0, 1'b0, 1'b1, 1'b1);
      e = sbq.pop_front(); total++;
      if (observe() !== e) begin
        bad++;
        $display("[TB] FAIL back_to_back[%0d]: got %h want %h", i, observe(), e);
      end
    end
    step(8'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    e = sbq.pop_front(); total++;
    if (observe() !== e) begin
      bad++;
      $display("[TB] FAIL back_to_back_end: got %h want %h", observe(), e);
    end
  endtask

  task automatic test_mid_reset();
    obs_t e;
    step(8'd46, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    e = sbq.pop_front();
    e = sbq.pop_front(); total++;
    if (observe() !== e || snap_valid_out !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_reset_setup: got %h want %h", observe(), e);
    end
    #2;
    reset_al_in = 1'b0;
    #1;
    total++;
    if (observe() !== obs_t'('0)) begin
      bad++;
      $display("[TB] FAIL mid_reset_async: got %h want 0", observe());
    end
    model_reset();
    @(posedge clk);
    #1;
    reset_al_in = 1'b1;
    step(8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    e = sbq.pop_front(); total++;
    if (observe() !== e) begin
      bad++;
      $display("[TB] FAIL mid_reset_after: got %h want %h", observe(), e);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_natural_wrap();
    test_load_zero();
    test_rollover();
    test_handshake();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
